// File: rtl/sadd_accum_pkg.sv
// sadd_accum_pkg: state encodings shared by sequential components
package sadd_accum_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sadd_accum_sadd.sv
// sadd_accum_sadd: combinational signed adder
module sadd_accum_sadd #(
  parameter int DATAWIDTH = 8
) (
  input  logic signed [DATAWIDTH-1:0] a,
  input  logic signed [DATAWIDTH-1:0] b,
  output logic signed [DATAWIDTH-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/sadd_accum.sv
// sadd_accum: accumulates COUNT signed samples into one guarded result
module sadd_accum
  import sadd_accum_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int COUNT     = 4,
  parameter int GUARD     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATAWIDTH-1:0]       din,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATAWIDTH+GUARD-1:0] dout
);
  localparam int W  = DATAWIDTH + GUARD;
  localparam int CW = $clog2(COUNT + 1) < 1 ? 1 : $clog2(COUNT + 1);
  state_t state, state_nx;
  logic [W-1:0] acc, sum, ext, acc_op;
  logic [CW-1:0] cnt, cnt_nx;
  logic take, last;
  assign in_ready  = state != DONE;
  assign out_valid = state == DONE;
  assign take      = in_valid && in_ready;
  assign ext       = {{GUARD{din[DATAWIDTH-1]}}, din};
  // IDLE restarts from zero so the first sample loads rather than adds
  assign acc_op    = state == ACC ? acc : '0;
  assign cnt_nx    = (state == ACC ? cnt : '0) + CW'(1);
  assign last      = take && cnt_nx == CW'(COUNT);
  sadd_accum_sadd #(.DATAWIDTH(W)) u_sadd (.a(acc_op), .b(ext), .sum(sum));
  always_comb begin
    state_nx = state;
    if (state == DONE) state_nx = out_ready ? IDLE : DONE;
    else if (take) state_nx = last ? DONE : ACC;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == DONE && out_ready) begin
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      acc <= sum;
      cnt <= cnt_nx;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) dout <= '0;
    else if (last) dout <= sum;
endmodule

// File: tb/tb_sadd_accum.sv
// tb_sadd_accum: directed scoreboard bench for sadd_accum
module tb_sadd_accum;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] din = '0;
  logic in_ready, out_valid;
  logic [11:0] dout;
  int checks = 0, errors = 0;
  int m_acc = 0, m_cnt = 0;
  logic [11:0] exp_q[$];
  logic [11:0] held;

  sadd_accum #(.DATAWIDTH(8), .COUNT(4), .GUARD(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
  );

  always #5 if (run) clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [7:0] d);
    in_valid = 1'b1;
    din = d;
    chk("in_ready_before_take", {11'd0, in_ready}, 12'd1);
    @(negedge clk);
    m_acc += $signed(d);
    m_cnt++;
    if (m_cnt == 4) begin
      exp_q.push_back(12'(m_acc));
      m_acc = 0;
      m_cnt = 0;
    end
    chk("out_valid_after_take", {11'd0, out_valid}, m_cnt == 0 ? 12'd1 : 12'd0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic collect(input string tag);
    int t;
    logic [11:0] e;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid"}, {11'd0, out_valid}, 12'd1);
    e = exp_q.size() > 0 ? exp_q.pop_front() : 12'hxxx;
    chk({tag, "_dout"}, dout, e);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, {11'd0, out_valid}, 12'd0);
    chk({tag, "_idle_ready"}, {11'd0, in_ready}, 12'd1);
    chk({tag, "_hold"}, dout, e);
  endtask

  initial begin
    #3;
    chk("reset_out_valid", {11'd0, out_valid}, 12'd0);
    chk("reset_dout", dout, 12'h000);
    chk("reset_in_ready", {11'd0, in_ready}, 12'd1);
    run = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    feed(8'd10); feed(8'd20); feed(-8'sd5); feed(8'd7);
    chk("sum32_value", dout, 12'h020);
    collect("sum32");

    repeat (4) feed(8'h80);
    collect("min");
    chk("min_value", dout, 12'hE00);
    repeat (4) feed(8'h7F);
    collect("max");
    chk("max_value", dout, 12'h1FC);

    feed(8'd5); feed(8'd6); feed(8'd7); feed(8'd8);
    held = dout;
    in_valid = 1'b1;
    din = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_dout", dout, held);
      chk("stall_ready", {11'd0, in_ready}, 12'd0);
      chk("stall_valid", {11'd0, out_valid}, 12'd1);
    end
    collect("stall");

    feed(8'd1); idle(2); feed(8'd2); feed(8'd3); idle(3); feed(8'd4);
    idle(1);
    collect("gaps");
    chk("gaps_value", dout, 12'd10);

    feed(8'd50); feed(8'd60);
    idle(0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", {11'd0, out_valid}, 12'd0);
    chk("midrst_dout", dout, 12'h000);
    chk("midrst_ready", {11'd0, in_ready}, 12'd1);
    m_acc = 0;
    m_cnt = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    repeat (4) feed(8'd1);
    collect("after_rst");
    chk("after_rst_value", dout, 12'd4);
    chk("queue_empty", 12'(exp_q.size()), 12'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sadd_accum.md
SADD_ACCUM -- requirements
Module: sadd_accum

Interface
REQ-001 The parameter list SHALL be: DATAWIDTH, default 8, the signed sample width.
REQ-002 The parameter list SHALL be: COUNT, default 4, the number of samples per result (1..2^GUARD).
REQ-003 The parameter list SHALL be: GUARD, default 4, the guard bits added to the result width.
REQ-004 Clk  input  1  is the rising-edge clock; the block SHALL use only this clock.
REQ-005 Rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 in_valid  input  1  SHALL indicate that din carries a sample.
REQ-007 din  input  DATAWIDTH  SHALL be a signed sample, typically the sum output of an upstream signed adder.
REQ-008 in_ready  output  1  SHALL indicate that the block accepts a sample this cycle.
REQ-009 out_valid  output  1  SHALL indicate that dout holds a completed result.
REQ-010 out_ready  input  1  SHALL indicate that the consumer takes dout this cycle.
REQ-011 dout  output  DATAWIDTH+GUARD  SHALL be the signed accumulated result.

Function
REQ-012 A sample SHALL be accepted only on a rising Clk edge where in_valid=1 and in_ready=1; cycles without acceptance SHALL not count.
REQ-013 The FSM SHALL have three states: IDLE, ACC and DONE.
REQ-014 In IDLE and ACC, in_ready SHALL be 1; in DONE, in_ready SHALL be 0.
REQ-015 IDLE -> ACC: the first accepted sample SHALL load the accumulator with sign-extended din and set the sample count to 1.
REQ-016 In ACC, each accepted sample SHALL be added to the accumulator and increment the count, with both operands sign-extended to DATAWIDTH+GUARD bits.
REQ-017 ACC -> DONE: when the accepted sample makes the count equal COUNT, the FSM SHALL move to DONE.
REQ-018 With COUNT=1, IDLE SHALL go directly to DONE on the first accepted sample.
REQ-019 out_valid SHALL be 1 exactly while in DONE, starting the cycle after the COUNT-th sample is accepted (latency 1 cycle).
REQ-020 dout SHALL be registered and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 DONE -> IDLE SHALL occur on the edge where out_valid=1 and out_ready=1; the accumulator and count SHALL clear on that edge.
REQ-022 The block SHALL insert one bubble cycle between results, accepting no sample during the handshake cycle.
REQ-023 in_valid asserted in DONE SHALL be ignored, with no state change.
REQ-024 dout SHALL hold its last value in IDLE and ACC, and SHALL change only on entry to DONE or on reset.
REQ-025 With COUNT <= 2^GUARD, no overflow can occur; no saturation logic SHALL be implemented.
REQ-026 The count register width SHALL be $clog2(COUNT+1) bits, minimum 1.

Reset
REQ-027 Rst=1 SHALL force IDLE, accumulator=0, count=0, dout=0, out_valid=0 and in_ready=1 immediately, independent of Clk.
REQ-028 Reset mid-accumulation or in DONE SHALL discard the partial or pending result; the first accepted sample after reset deassertion SHALL start a new result.

Structure
REQ-029 The state encodings (IDLE=2'd0, ACC=2'd1, DONE=2'd2) SHALL be localparams in a shared component include file, reused by other sequential components.
REQ-030 The adder SHALL be one instance of the existing signed adder component SADD with DATAWIDTH=DATAWIDTH+GUARD; the FSM, count and registers SHALL be local.
REQ-031 The block SHALL use no latches and one always block per register group, all clocked on Clk with asynchronous Rst.

Verification (DATAWIDTH=8, COUNT=4, GUARD=4)
REQ-032 Assert Rst with no clock running -> out_valid=0, dout=12'h000, in_ready=1.
REQ-033 Feed din=10, 20, -5, 7 on four consecutive edges -> out_valid=1 one cycle after the 4th sample; dout=32 (12'h020).
REQ-034 Feed four samples of -128 -> dout=-512 (12'hE00); then feed four samples of 127 -> dout=508 (12'h1FC).
REQ-035 Hold out_ready=0 for 5 cycles after a result with in_valid=1 and din=99 -> dout stays stable, in_ready=0, no sample counted; out_ready=1 -> IDLE next cycle.
REQ-036 Feed samples 1, 2, 3, 4 with in_valid gaps of 0-3 cycles -> dout=10; out_valid rises only after the 4th accepted sample.
REQ-037 Accept 50 and 60, then pulse Rst, then feed 1, 1, 1, 1 -> dout=4; no stale result is ever presented.
